// File: rtl/id_ex_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_pipe_pkg
//  Purpose  : Shared widths, bubble encoding, opcode constants and the
//             memory/writeback control bundle for the ID/EX pipeline slice.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package id_ex_pipe_pkg;

    localparam int DATA_W = 16;
    localparam int RA_W   = 4;

    // instr_EX value presented while the EX slot holds a bubble
    localparam logic [DATA_W-1:0] BUBBLE_INSTR = 16'h0000;

    // Opcode field values (instr[15:12]) of interest to later stages
    localparam logic [3:0] c_OP_HLT = 4'hF;
    localparam logic [3:0] c_OP_LW  = 4'h8;
    localparam logic [3:0] c_OP_SW  = 4'h9;

    typedef struct packed {
        logic LdByte;
        logic MemOp;
        logic MemRead;
        logic MemWrite;
        logic RegWrite;
        logic Halt;
    } ctrl_t;

    // All-inactive control bundle carried by a bubble
    function automatic ctrl_t ctrl_none();
        return '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_pipe_if
//  Purpose  : Bundles the ID-stage inputs, pipeline control and EX-stage
//             outputs of the ID/EX register.
//  Ports    : master - decode side: drives ID fields, stall_in, flush;
//                      observes EX fields, load_use_stall, halted.
//             slave  - the pipeline register itself (opposite directions).
//  Revision : 1.0  initial release
// ============================================================================
interface id_ex_pipe_if;
    import id_ex_pipe_pkg::*;

    // ID-stage side
    logic [DATA_W-1:0] instr_ID;
    logic [DATA_W-1:0] RegData1_ID;
    logic [DATA_W-1:0] RegData2_ID;
    logic [DATA_W-1:0] pcs_ID;
    logic              LdByte_ID;
    logic              MemOp_ID;
    logic              MemRead_ID;
    logic              MemWrite_ID;
    logic              RegWrite_ID;
    logic              Halt_ID;
    logic [RA_W-1:0]   rs_ID;
    logic [RA_W-1:0]   rt_ID;
    logic [RA_W-1:0]   rd_ID;
    logic              rs_used_ID;
    logic              rt_used_ID;
    logic              stall_in;
    logic              flush;

    // EX-stage side
    logic [DATA_W-1:0] instr_EX;
    logic [DATA_W-1:0] RegData1_EX;
    logic [DATA_W-1:0] RegData2_EX;
    logic [DATA_W-1:0] pcs_EX;
    logic              LdByte_EX;
    logic              MemOp_EX;
    logic              MemRead_EX;
    logic              MemWrite_EX;
    logic              RegWrite_EX;
    logic              Halt_EX;
    logic [RA_W-1:0]   rs_EX;
    logic [RA_W-1:0]   rt_EX;
    logic [RA_W-1:0]   rd_EX;
    logic              valid_EX;
    logic              load_use_stall;
    logic              halted;

    modport master (
        output instr_ID, RegData1_ID, RegData2_ID, pcs_ID,
               LdByte_ID, MemOp_ID, MemRead_ID, MemWrite_ID, RegWrite_ID, Halt_ID,
               rs_ID, rt_ID, rd_ID, rs_used_ID, rt_used_ID, stall_in, flush,
        input  instr_EX, RegData1_EX, RegData2_EX, pcs_EX,
               LdByte_EX, MemOp_EX, MemRead_EX, MemWrite_EX, RegWrite_EX, Halt_EX,
               rs_EX, rt_EX, rd_EX, valid_EX, load_use_stall, halted
    );

    modport slave (
        input  instr_ID, RegData1_ID, RegData2_ID, pcs_ID,
               LdByte_ID, MemOp_ID, MemRead_ID, MemWrite_ID, RegWrite_ID, Halt_ID,
               rs_ID, rt_ID, rd_ID, rs_used_ID, rt_used_ID, stall_in, flush,
        output instr_EX, RegData1_EX, RegData2_EX, pcs_EX,
               LdByte_EX, MemOp_EX, MemRead_EX, MemWrite_EX, RegWrite_EX, Halt_EX,
               rs_EX, rt_EX, rd_EX, valid_EX, load_use_stall, halted
    );

endinterface
`default_nettype wire

// File: rtl/id_ex_pipe_hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_pipe_hazard_detect
//  Purpose  : Combinational load-use hazard detection. Flags when the load
//             sitting in EX writes a register that the ID instruction reads.
//  Ports    : i_valid_ex, i_mem_read_ex, i_reg_write_ex, i_rd_ex - EX load
//             i_rs_id, i_rt_id, i_rs_used_id, i_rt_used_id       - ID reads
//             o_load_use_stall                                    - hazard
//  Revision : 1.0  initial release
// ============================================================================
module id_ex_pipe_hazard_detect
    import id_ex_pipe_pkg::*;
(
    input  wire logic            i_valid_ex,
    input  wire logic            i_mem_read_ex,
    input  wire logic            i_reg_write_ex,
    input  wire logic [RA_W-1:0] i_rd_ex,
    input  wire logic [RA_W-1:0] i_rs_id,
    input  wire logic [RA_W-1:0] i_rt_id,
    input  wire logic            i_rs_used_id,
    input  wire logic            i_rt_used_id,
    output logic                 o_load_use_stall
);

    logic w_ex_is_load;
    logic w_src_match;

    // Register 0 is hard-wired, so a load targeting it never creates a hazard
    assign w_ex_is_load = i_valid_ex & i_mem_read_ex & i_reg_write_ex & (i_rd_ex != '0);

    assign w_src_match  = (i_rs_used_id & (i_rs_id == i_rd_ex)) |
                          (i_rt_used_id & (i_rt_id == i_rd_ex));

    assign o_load_use_stall = w_ex_is_load & w_src_match;

endmodule
`default_nettype wire

// File: rtl/id_ex_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_pipe
//  Purpose  : ID/EX pipeline register. Captures the decoded instruction,
//             operands, pcs, controls and register addresses each cycle, with
//             downstream stall, deferred branch flush, load-use bubble
//             insertion and a sticky halt.
//  Ports    : clk   - rising-edge clock
//             rst_n - synchronous active-low reset
//             bus   - id_ex_pipe_if.slave: ID inputs, stall_in, flush in;
//                     EX outputs, valid_EX, load_use_stall, halted out
//  Revision : 1.0  initial release
// ============================================================================
module id_ex_pipe
    import id_ex_pipe_pkg::*;
(
    input  wire logic    clk,
    input  wire logic    rst_n,
    id_ex_pipe_if.slave  bus
);

    logic [DATA_W-1:0] r_instr;
    logic [DATA_W-1:0] r_data1;
    logic [DATA_W-1:0] r_data2;
    logic [DATA_W-1:0] r_pcs;
    ctrl_t             r_ctrl;
    logic [RA_W-1:0]   r_rs;
    logic [RA_W-1:0]   r_rt;
    logic [RA_W-1:0]   r_rd;
    logic              r_valid;
    logic              r_halted;
    // A flush seen while stalled is remembered and applied on the first
    // unstalled cycle, so the killed instruction cannot slip through.
    logic              r_flush_pending;

    ctrl_t             w_ctrl_id;
    logic              w_load_use;
    logic              w_bubble;

    assign w_ctrl_id = '{
        LdByte   : bus.LdByte_ID,
        MemOp    : bus.MemOp_ID,
        MemRead  : bus.MemRead_ID,
        MemWrite : bus.MemWrite_ID,
        RegWrite : bus.RegWrite_ID,
        Halt     : bus.Halt_ID
    };

    id_ex_pipe_hazard_detect u_hazard (
        .i_valid_ex       (r_valid),
        .i_mem_read_ex    (r_ctrl.MemRead),
        .i_reg_write_ex   (r_ctrl.RegWrite),
        .i_rd_ex          (r_rd),
        .i_rs_id          (bus.rs_ID),
        .i_rt_id          (bus.rt_ID),
        .i_rs_used_id     (bus.rs_used_ID),
        .i_rt_used_id     (bus.rt_used_ID),
        .o_load_use_stall (w_load_use)
    );

    // Any of these turns the capture into a bubble; halted dominates because
    // nothing may enter EX after a halt until reset.
    assign w_bubble = r_halted | bus.flush | r_flush_pending | w_load_use;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instr         <= BUBBLE_INSTR;
            r_data1         <= '0;
            r_data2         <= '0;
            r_pcs           <= '0;
            r_ctrl          <= ctrl_none();
            r_rs            <= '0;
            r_rt            <= '0;
            r_rd            <= '0;
            r_valid         <= 1'b0;
            r_halted        <= 1'b0;
            r_flush_pending <= 1'b0;
        end else if (bus.stall_in) begin
            if (bus.flush) begin
                r_flush_pending <= 1'b1;
            end
        end else if (w_bubble) begin
            // Data, pcs and addresses keep their old values on a bubble;
            // only the fields that can cause side effects are cleared.
            r_instr         <= BUBBLE_INSTR;
            r_ctrl          <= ctrl_none();
            r_valid         <= 1'b0;
            r_flush_pending <= 1'b0;
        end else begin
            r_instr  <= bus.instr_ID;
            r_data1  <= bus.RegData1_ID;
            r_data2  <= bus.RegData2_ID;
            r_pcs    <= bus.pcs_ID;
            r_ctrl   <= w_ctrl_id;
            r_rs     <= bus.rs_ID;
            r_rt     <= bus.rt_ID;
            r_rd     <= bus.rd_ID;
            r_valid  <= 1'b1;
            if (bus.Halt_ID) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign bus.instr_EX       = r_instr;
    assign bus.RegData1_EX    = r_data1;
    assign bus.RegData2_EX    = r_data2;
    assign bus.pcs_EX         = r_pcs;
    assign bus.LdByte_EX      = r_ctrl.LdByte;
    assign bus.MemOp_EX       = r_ctrl.MemOp;
    assign bus.MemRead_EX     = r_ctrl.MemRead;
    assign bus.MemWrite_EX    = r_ctrl.MemWrite;
    assign bus.RegWrite_EX    = r_ctrl.RegWrite;
    assign bus.Halt_EX        = r_ctrl.Halt;
    assign bus.rs_EX          = r_rs;
    assign bus.rt_EX          = r_rt;
    assign bus.rd_EX          = r_rd;
    assign bus.valid_EX       = r_valid;
    assign bus.load_use_stall = w_load_use;
    assign bus.halted         = r_halted;

endmodule
`default_nettype wire
